// File: rtl/burst_rr_arbiter_pkg.sv
// Shared types and default constants for the burst round-robin arbiter.
// Optional feature macro: ARB_LOCK_EN (adds the lock input that suppresses
// quota preemption while asserted).
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_N_DEF        = 4;
    localparam int ARB_MAX_HOLD_DEF = 8;

endpackage : arb_pkg

// File: rtl/burst_rr_arbiter_if.sv
// Requester-side bundle of the burst round-robin arbiter.
// Optional feature macro: ARB_LOCK_EN (adds the lock signal to the bundle).
// master = requester/datapath side, slave = arbiter side.
interface burst_rr_arbiter_if
    import arb_pkg::*;
#(
    parameter int N  = ARB_N_DEF,
    parameter int IW = $clog2(N)
);

    logic [N-1:0]  request;
    logic          done;
    logic [N-1:0]  grant;
    logic          busy;
    logic [IW-1:0] owner_id;

`ifdef ARB_LOCK_EN
    logic          lock;

    modport master (
        output request, done, lock,
        input  grant, busy, owner_id
    );

    modport slave (
        input  request, done, lock,
        output grant, busy, owner_id
    );
`else
    modport master (
        output request, done,
        input  grant, busy, owner_id
    );

    modport slave (
        input  request, done,
        output grant, busy, owner_id
    );
`endif

endinterface : burst_rr_arbiter_if

// File: rtl/burst_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker: returns the first set request bit
// searching circularly from ptr+1 up to and including ptr, so the index held
// in ptr (the previous winner) has the lowest priority.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N  = ARB_N_DEF,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Circular first-set search starting just after the last winner.
    always_comb begin : pick_search
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter with burst tenure. The owner keeps its grant until it
// pulses done, drops its request, or reaches MAX_HOLD cycles while another
// requester waits. Hand-over is registered and bubble-free: the old grant bit
// clears and the new one sets on the same edge.
// Optional feature macro: ARB_LOCK_EN (lock input suppresses the quota
// release while a grant is held; done and request drop still release).
module burst_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N_DEF,
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEF,
    parameter int IW       = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    burst_rr_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAX_HOLD + 1);

    arb_state_t     state_q;
    logic [N-1:0]   grant_q;
    logic           busy_q;
    logic [IW-1:0]  owner_q;
    logic [IW-1:0]  ptr_q;
    logic [CW-1:0]  cnt_q;

    logic [N-1:0]   pick_onehot;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic           lock_hold;
    logic           owner_req;
    logic           others_req;
    logic           quota_hit;
    logic           release_now;

    // One picker serves both the idle start-up and the hand-over decision;
    // in GRANT, ptr equals the owner, so the owner is searched last.
    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (bus.request),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

`ifdef ARB_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Release causes, evaluated against the registered grant vector.
    assign owner_req   = |(bus.request & grant_q);
    assign others_req  = |(bus.request & ~grant_q);
    assign quota_hit   = (cnt_q == CW'(MAX_HOLD)) && others_req && !lock_hold;
    assign release_now = bus.done || !owner_req || quota_hit;

    // Arbitration FSM with registered grant, busy, owner and hold counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= IW'(N - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        state_q <= ARB_GRANT;
                        grant_q <= pick_onehot;
                        busy_q  <= 1'b1;
                        owner_q <= pick_idx;
                        ptr_q   <= pick_idx;
                        cnt_q   <= CW'(1);
                    end
                end
                ARB_GRANT: begin
                    if (release_now) begin
                        if (pick_any) begin
                            // Direct hand-over (possibly back to the same owner).
                            grant_q <= pick_onehot;
                            owner_q <= pick_idx;
                            ptr_q   <= pick_idx;
                            cnt_q   <= CW'(1);
                        end else begin
                            // Nobody left: owner_id keeps its last value.
                            state_q <= ARB_IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end else if (cnt_q != CW'(MAX_HOLD)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.owner_id = owner_q;

endmodule : burst_rr_arbiter
